controle_es: RTL
================

Name: controle_es

Overview:
- Peripheral-side I/O controller for the processor's `in`/`out` instructions.
- For `in`: the control unit stalls the core with `stop` until `sinal` is high. This block is the device end of that handshake. It debounces the confirm pushbutton, latches the switch value and raises `sinal` for one cycle so the core can retire the instruction.
- For `out`: it captures the core's output operand into a held display register.
- It sits between the board pins (button, switches, 7-segment/LED driver) and the datapath/control unit.

Parameters:
- DEB_CICLOS, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be ≥2.
- LARG_CHAVES, 16, width of the switch input.
- LARG_DADO, 32, datapath word width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- botao  input  1  raw confirm pushbutton, active-high, asynchronous to clock.
- chaves  input  LARG_CHAVES  raw switch bank.
- in  input  1  control unit is executing `in` and waiting (stall path).
- out  input  1  control unit is executing `out`.
- dado_saida_cpu  input  LARG_DADO  operand to display, valid when out=1.
- sinal  output  1  input data ready; drives the control unit's `sinal`.
- dado_entrada  output  LARG_DADO  latched switch value, zero-extended.
- display  output  LARG_DADO  last value written by `out`.
- aguardando  output  1  core is waiting for user input (LED).

Behaviour:
- Reset (reset=0, async) values: sinal=0, dado_entrada=0, display=0, aguardando=0, FSM=OCIOSO, debounce counter=0, debounced level=0, synchronizer flops=0.
- Synchronizer: botao passes through 2 flops giving botao_s; chaves are sampled only at latch time.
- Debounce:
  - The counter increments each cycle botao_s differs from the stable level estavel.
  - The counter clears whenever botao_s equals estavel.
  - When the counter reaches DEB_CICLOS-1 and botao_s still differs, estavel toggles and the counter clears.
  - Pulses shorter than DEB_CICLOS cycles are ignored.
- confirma: a one-cycle pulse when estavel goes 0→1 (rising edge only).
- FSM (Moore outputs, registered):
  - OCIOSO: sinal=0, aguardando=0. in=1 → AGUARDA. confirma here is ignored.
  - AGUARDA: aguardando=1.
    - confirma=1 → dado_entrada <= zero-extended chaves sampled that cycle, then ENTREGA.
    - in=0 (abort) → OCIOSO.
  - ENTREGA: sinal=1 for exactly one cycle, aguardando=0, → LIBERA. The core writes the register and advances the PC on this edge.
  - LIBERA: sinal=0. Waits for estavel=0, then → OCIOSO. One press delivers exactly one value.
- A button already held when `in` arrives is not accepted; it must be released and pressed again.
- Latency: confirma at edge k → sinal high in cycle k+1 → sinal low at k+2. From the first sampled botao=1 to sinal=1 is DEB_CICLOS+3 edges.
- dado_entrada holds until the next accepted input; it is never cleared except by reset.
- Output path: on any edge with out=1, display <= dado_saida_cpu. Otherwise display holds. There is no latency beyond one edge.
- out and in are independent. Simultaneous assertion (illegal opcode overlap) is served by both paths without interaction.
- Reset mid-handshake (any state) returns to OCIOSO; sinal drops asynchronously.

Decomposition:
- Shared package holds:
  - FSM state encoding: OCIOSO=2'd0, AGUARDA=2'd1, ENTREGA=2'd2, LIBERA=2'd3.
  - LARG_DADO.
  - Opcode constants OP_OUT=6'b001110 and OP_IN=6'b001111, shared with the control unit.
- Sub-module filtro_botao, which contains the synchronizer, the debounce counter (width $clog2(DEB_CICLOS)) and confirma generation. It is reused for a future reset/step button.

Test Plan:
- DEB_CICLOS=4, reset released, no stimulus → sinal=0, display=0, dado_entrada=0 for 50 cycles.
- in=1, chaves=16'hA5C3, botao high for 20 cycles → aguardando=1 until confirma; dado_entrada=32'h0000A5C3; sinal=1 for exactly one cycle, 7 edges after first botao=1; FSM stays in LIBERA until release.
- in=1, botao glitches high for 2 cycles then low → sinal never asserts, aguardando stays 1.
- botao held high before in=1, then in=1 → no sinal; release 10 cycles then press 10 cycles → single sinal pulse.
- out=1 for one cycle with dado_saida_cpu=32'hDEADBEEF, then out=0 with new data 32'h1 → display=32'hDEADBEEF held.
- Assert reset while in ENTREGA → sinal=0 immediately, display=0; after release, a full press cycle works normally.

Source files
------------

// File: rtl/controle_es_pkg.sv
// Shared definitions for the in/out peripheral controller and the control unit.
package controle_es_pkg;

    localparam int unsigned LARG_DADO = 32;

    localparam logic [5:0] OP_OUT = 6'b001110;
    localparam logic [5:0] OP_IN  = 6'b001111;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        AGUARDA = 2'd1,
        ENTREGA = 2'd2,
        LIBERA  = 2'd3
    } estado_t;

endpackage

// File: rtl/controle_es_if.sv
// Core-side handshake bus between the control unit/datapath and controle_es.
interface controle_es_if;
    import controle_es_pkg::*;

    logic                 in;
    logic                 out;
    logic [LARG_DADO-1:0] dado_saida_cpu;
    logic                 sinal;
    logic [LARG_DADO-1:0] dado_entrada;

    modport master (
        output in, out, dado_saida_cpu,
        input  sinal, dado_entrada
    );

    modport slave (
        input  in, out, dado_saida_cpu,
        output sinal, dado_entrada
    );

endinterface

// File: rtl/controle_es_filtro_botao.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce filter and rising-edge pulse.
module filtro_botao #(
    parameter int unsigned DEB_CICLOS = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_i,
    output logic estavel_o,
    output logic confirma_o
);

    localparam int unsigned         LARG_CNT = $clog2(DEB_CICLOS);
    localparam logic [LARG_CNT-1:0] CNT_MAX  = LARG_CNT'(DEB_CICLOS - 1);

    logic [1:0]          sinc_q;
    logic                botao_s;
    logic                estavel_q, estavel_d;
    logic                estavel_ant_q;
    logic [LARG_CNT-1:0] cnt_q, cnt_d;

    assign botao_s = sinc_q[1];

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (botao_s != estavel_q) begin
            if (cnt_q == CNT_MAX) begin
                estavel_d = ~estavel_q;
            end else begin
                cnt_d = cnt_q + LARG_CNT'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc_q        <= '0;
            estavel_q     <= 1'b0;
            estavel_ant_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sinc_q        <= {sinc_q[0], botao_i};
            estavel_q     <= estavel_d;
            estavel_ant_q <= estavel_q;
            cnt_q         <= cnt_d;
        end
    end

    assign estavel_o  = estavel_q;
    assign confirma_o = estavel_q & ~estavel_ant_q;

endmodule

// File: rtl/controle_es.sv
// Device end of the in/out instructions: debounced confirm handshake for `in`,
// held display register for `out`.
module controle_es
    import controle_es_pkg::*;
#(
    parameter int unsigned DEB_CICLOS  = 500000,
    parameter int unsigned LARG_CHAVES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   botao,
    input  logic [LARG_CHAVES-1:0] chaves,
    controle_es_if.slave           cpu,
    output logic [LARG_DADO-1:0]   display,
    output logic                   aguardando
);

    logic                 estavel;
    logic                 confirma;
    estado_t              estado_q, estado_d;
    logic                 sinal_q, sinal_d;
    logic                 aguardando_q, aguardando_d;
    logic [LARG_DADO-1:0] dado_entrada_q, dado_entrada_d;
    logic [LARG_DADO-1:0] display_q, display_d;

    filtro_botao #(
        .DEB_CICLOS(DEB_CICLOS)
    ) u_filtro (
        .clock     (clock),
        .reset     (reset),
        .botao_i   (botao),
        .estavel_o (estavel),
        .confirma_o(confirma)
    );

    always_comb begin
        estado_d       = estado_q;
        dado_entrada_d = dado_entrada_q;
        case (estado_q)
            OCIOSO:  if (cpu.in) estado_d = AGUARDA;
            AGUARDA: begin
                if (confirma) begin
                    dado_entrada_d = LARG_DADO'(chaves);
                    estado_d       = ENTREGA;
                end else if (!cpu.in) begin
                    estado_d = OCIOSO;
                end
            end
            ENTREGA: estado_d = LIBERA;
            // Holding here until release makes one press deliver one value.
            LIBERA:  if (!estavel) estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        sinal_d      = (estado_d == ENTREGA);
        aguardando_d = (estado_d == AGUARDA);
        display_d    = cpu.out ? cpu.dado_saida_cpu : display_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q       <= OCIOSO;
            sinal_q        <= 1'b0;
            aguardando_q   <= 1'b0;
            dado_entrada_q <= '0;
            display_q      <= '0;
        end else begin
            estado_q       <= estado_d;
            sinal_q        <= sinal_d;
            aguardando_q   <= aguardando_d;
            dado_entrada_q <= dado_entrada_d;
            display_q      <= display_d;
        end
    end

    assign cpu.sinal        = sinal_q;
    assign cpu.dado_entrada = dado_entrada_q;
    assign display          = display_q;
    assign aguardando       = aguardando_q;

endmodule
